high_score_tracker: RTL and testbench
=====================================

# high_score_tracker

Keeps the session high score for the dinosaur game. It sits directly downstream of the 5-digit BCD score counter. On each game-over event it snapshots the counter's 20-bit BCD value and compares it against the stored high score, one digit per cycle, most significant digit first. If the snapshot is strictly greater, it replaces the stored value and flags a new record; the stored value drives the score display.

## Interface
- No parameters; digit count fixed at 5 (20-bit BCD, digit 4 = bits [19:16] most significant, digit 0 = bits [3:0]).
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  reset, asynchronous, active-high; clears all state.
- score  input  20  BCD score from the score counter; only sampled on an accepted game_over.
- game_over  input  1  level sampled each edge; accepted only in IDLE.
- high  output  20  stored high score, BCD.
- new_record  output  1  last accepted comparison produced a new high score.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse, comparison finished.
- bad_digit  output  1  snapshot contained a digit > 9 (see Configuration).

## Operation
- States: IDLE, CMP, UPD, DONE.
- IDLE with game_over=1 at an edge:
  - snap <= score
  - idx <= 4
  - new_record <= 0
  - bad_digit updated
  - -> CMP
- IDLE with game_over=0: hold.
- CMP, one digit per edge, snap[idx] vs high[idx] as unsigned 4-bit:
  - greater -> UPD
  - less -> DONE
  - equal and idx>0 -> idx <= idx-1, stay in CMP
  - equal and idx==0 -> DONE (a tie is not a record)
- UPD:
  - high <= snap
  - new_record <= 1
  - -> DONE
- DONE: done=1 for this cycle; -> IDLE.
- game_over while busy is ignored, not queued. A held-high game_over retriggers on the first IDLE edge.
- score changes after acceptance do not affect the comparison; only snap is used.
- new_record and bad_digit hold their values until the next accepted game_over.
- clr at any time: async return to IDLE, with snap, high, idx, new_record, done and bad_digit all 0. A comparison in progress is abandoned.

## Timing
- Reset values: high=20'h00000, new_record=0, busy=0, done=0, bad_digit=0.
- busy, done and new_record are registered outputs, derived from state.
- Acceptance edge E0. busy rises after E0.
- Decision at digit k (k=4..0) occurs at edge E(5-k).
- Record path: the UPD edge follows the decision edge. high and new_record change after that edge, and done is high in the following cycle.
  - Best case (digit 4 greater): high updates after E2; done high between E2 and E3.
  - Worst case (greater at digit 0): high updates after E6; done high between E6 and E7.
- No-record path: done high the cycle after the decision edge; for a full tie that is between E5 and E6.
- busy falls on the edge that ends DONE.
- Next game_over is accepted on the first edge where state=IDLE, at the earliest the edge that ends DONE plus one.

## Configuration
- Macro HS_DIGIT_CLAMP_EN.
- Defined:
  - At acceptance, each score digit > 9 is clamped to 9 in snap.
  - bad_digit <= 1 if any digit was > 9, else 0.
- Undefined:
  - Digits are copied raw and compared as unsigned 4-bit.
  - bad_digit is constant 0.

## Test plan
- Reset then idle: clr pulse mid-cycle -> high=00000, busy=0, done=0, new_record=0 immediately, without waiting for a clock edge.
- First game: score=20'h00123, game_over one cycle -> done one cycle later than the DONE-state timing above, high=00123, new_record=1.
- Lower score: high=00123, score=20'h00099 -> decision at digit 2 (less), high unchanged, new_record=0, done pulse between E3 and E4.
- Tie and LSD win:
  - score=20'h00123 -> tie, done between E5 and E6, new_record=0.
  - Then score=20'h00124 -> high=00124 after E6.
- Busy/reset robustness:
  - game_over held high through a comparison -> exactly one retrigger after returning to IDLE.
  - clr asserted during CMP -> IDLE, high=00000.
- Clamp (HS_DIGIT_CLAMP_EN defined), score=20'h0A005 -> snap 09005, bad_digit=1, high=09005. Undefined -> high=0A005, bad_digit=0.

Source files
------------

// File: rtl/high_score_tracker.sv
//------------------------------------------------------------------------------
// Module      : high_score_tracker
// Description : Session high-score keeper for the dinosaur game. On game_over
//               it snapshots the 5-digit BCD score and compares it against the
//               stored high score, most significant digit first. It compares
//               one digit per cycle. A strictly greater snapshot replaces the
//               stored value and raises new_record.
//               Optional macro HS_DIGIT_CLAMP_EN: clamps snapshot digits above
//               9 down to 9 and reports the clamp on bad_digit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module high_score_tracker (
    input  logic        clk,
    input  logic        clr,
    input  logic [19:0] score,
    input  logic        game_over,
    output logic [19:0] high,
    output logic        new_record,
    output logic        busy,
    output logic        done,
    output logic        bad_digit
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_UPD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [19:0] r_snap;
    logic [19:0] r_high;
    logic [2:0]  r_idx;
    logic        r_new_record;
    logic        r_busy;
    logic        r_done;
    logic        r_bad_digit;
    logic [19:0] w_snap_in;
    logic        w_bad_in;
    logic [3:0]  w_snap_dig;
    logic [3:0]  w_high_dig;

`ifdef HS_DIGIT_CLAMP_EN
    logic [4:0] w_dig_bad;

    // Clamp each incoming digit to 9 and flag any digit that needed it
    for (genvar gi = 0; gi < 5; gi++) begin : g_clamp
        assign w_dig_bad[gi]          = (score[4*gi +: 4] > 4'd9);
        assign w_snap_in[4*gi +: 4]   = w_dig_bad[gi] ? 4'd9 : score[4*gi +: 4];
    end
    assign w_bad_in = |w_dig_bad;
`else
    assign w_snap_in = score;
    assign w_bad_in  = 1'b0;
`endif

    // Select the digit pair currently under comparison
    always_comb begin
        w_snap_dig = r_snap[3:0];
        w_high_dig = r_high[3:0];
        case (r_idx)
            3'd4:    begin w_snap_dig = r_snap[19:16]; w_high_dig = r_high[19:16]; end
            3'd3:    begin w_snap_dig = r_snap[15:12]; w_high_dig = r_high[15:12]; end
            3'd2:    begin w_snap_dig = r_snap[11:8];  w_high_dig = r_high[11:8];  end
            3'd1:    begin w_snap_dig = r_snap[7:4];   w_high_dig = r_high[7:4];   end
            default: begin w_snap_dig = r_snap[3:0];   w_high_dig = r_high[3:0];   end
        endcase
    end

    // Next-state decision; a full tie ends without a record
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (game_over) w_next = S_CMP;
            S_CMP: begin
                if (w_snap_dig > w_high_dig)      w_next = S_UPD;
                else if (w_snap_dig < w_high_dig) w_next = S_DONE;
                else if (r_idx == 3'd0)           w_next = S_DONE;
                else                              w_next = S_CMP;
            end
            S_UPD:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, snapshot, stored score and registered status flags
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state      <= S_IDLE;
            r_snap       <= 20'h00000;
            r_high       <= 20'h00000;
            r_idx        <= 3'd0;
            r_new_record <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_bad_digit  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (game_over) begin
                        r_snap       <= w_snap_in;
                        r_idx        <= 3'd4;
                        r_new_record <= 1'b0;
                        r_bad_digit  <= w_bad_in;
                    end
                end
                S_CMP: begin
                    if ((w_snap_dig == w_high_dig) && (r_idx != 3'd0))
                        r_idx <= r_idx - 3'd1;
                end
                S_UPD: begin
                    r_high       <= r_snap;
                    r_new_record <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign high       = r_high;
    assign new_record = r_new_record;
    assign busy       = r_busy;
    assign done       = r_done;
    assign bad_digit  = r_bad_digit;

endmodule

`default_nettype wire

// File: tb/tb_high_score_tracker.sv
//------------------------------------------------------------------------------
// Module      : tb_high_score_tracker
// Description : Scoreboard bench for high_score_tracker. Stimulus pushes the
//               expected result of each accepted game; a monitor pops and
//               compares on every done pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_high_score_tracker;

    typedef struct {
        logic [19:0] high;
        logic        nr;
        logic        bd;
        int          start;
        int          lat;
        string       name;
    } exp_t;

    logic        clk;
    logic        clr;
    logic [19:0] score;
    logic        game_over;
    logic [19:0] high;
    logic        new_record;
    logic        busy;
    logic        done;
    logic        bad_digit;

    exp_t sb[$];
    int   cyc;
    int   n_pass;
    int   n_total;

    high_score_tracker dut (
        .clk        (clk),
        .clr        (clr),
        .score      (score),
        .game_over  (game_over),
        .high       (high),
        .new_record (new_record),
        .busy       (busy),
        .done       (done),
        .bad_digit  (bad_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor: compare every done pulse against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!clr && done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_high"},    32'(high),       32'(e.high));
                    check({e.name, "_nr"},      32'(new_record), 32'(e.nr));
                    check({e.name, "_bad"},     32'(bad_digit),  32'(e.bd));
                    check({e.name, "_latency"}, 32'(cyc - e.start), 32'(e.lat));
                    @(negedge clk);
                    check({e.name, "_done_pulse"}, 32'(done), 32'd0);
                    check({e.name, "_busy_fall"},  32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check({name, "_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_game(input logic [19:0] s, input logic [19:0] eh, input logic enr,
                            input logic ebd, input int lat, input logic scramble,
                            input string name);
        exp_t e;
        @(negedge clk);
        score     = s;
        game_over = 1'b1;
        @(posedge clk);
        @(negedge clk);
        game_over = 1'b0;
        if (scramble) score = 20'h99999;
        e.high = eh; e.nr = enr; e.bd = ebd; e.start = cyc; e.lat = lat; e.name = name;
        sb.push_back(e);
        check({name, "_busy_rise"}, 32'(busy), 32'd1);
        wait_empty(name);
    endtask

    initial begin
        exp_t e;
        int   s0;
        int   n;
        n_pass    = 0;
        n_total   = 0;
        clr       = 1'b0;
        score     = 20'h00000;
        game_over = 1'b0;

        // Asynchronous reset before any clock edge
        #2 clr = 1'b1;
        #1;
        check("rst_high", 32'(high),       32'h0);
        check("rst_busy", 32'(busy),       32'd0);
        check("rst_done", 32'(done),       32'd0);
        check("rst_nr",   32'(new_record), 32'd0);
        check("rst_bad",  32'(bad_digit),  32'd0);
        @(negedge clk);
        clr = 1'b0;

        // Record decided at digit 2 (1 > 0): UPD then DONE
        run_game(20'h00123, 20'h00123, 1'b1, 1'b0, 4, 1'b0, "first");
        // Less at digit 2
        run_game(20'h00099, 20'h00123, 1'b0, 1'b0, 3, 1'b0, "lower");
        // Full tie
        run_game(20'h00123, 20'h00123, 1'b0, 1'b0, 5, 1'b0, "tie");
        // Win at least significant digit, score scrambled after acceptance
        run_game(20'h00124, 20'h00124, 1'b1, 1'b0, 6, 1'b1, "lsd_win");
        // Win at most significant digit
        run_game(20'h10000, 20'h10000, 1'b1, 1'b0, 2, 1'b0, "msd_win");

        // game_over held high: one retrigger, two tie results
        @(negedge clk);
        score     = 20'h10000;
        game_over = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s0 = cyc;
        e.high = 20'h10000; e.nr = 1'b0; e.bd = 1'b0; e.lat = 5;
        e.start = s0;     e.name = "held_1"; sb.push_back(e);
        e.start = s0 + 7; e.name = "held_2"; sb.push_back(e);
        n = 0;
        while (cyc < s0 + 7 && n < 20) begin
            @(negedge clk);
            n++;
        end
        game_over = 1'b0;
        wait_empty("held");
        repeat (10) @(negedge clk);
        check("held_quiet_busy", 32'(busy), 32'd0);

        // Reset during a comparison abandons it and clears the high score
        @(negedge clk);
        score     = 20'h20000;
        game_over = 1'b1;
        @(posedge clk);
        @(negedge clk);
        game_over = 1'b0;
        check("midcmp_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #2 clr = 1'b1;
        #1;
        check("midcmp_high", 32'(high),       32'h0);
        check("midcmp_busy_clr", 32'(busy),   32'd0);
        check("midcmp_done", 32'(done),       32'd0);
        check("midcmp_nr",   32'(new_record), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        repeat (8) @(negedge clk);
        check("midcmp_stays_idle", 32'(busy), 32'd0);

        // Non-BCD digit: decided at digit 3 against a cleared high score
`ifdef HS_DIGIT_CLAMP_EN
        run_game(20'h0A005, 20'h09005, 1'b1, 1'b1, 3, 1'b0, "clamp");
`else
        run_game(20'h0A005, 20'h0A005, 1'b1, 1'b0, 3, 1'b0, "clamp");
`endif

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
